// File: rtl/sd_num_parser.sv
// ASCII decimal number parser for the SD file reader byte stream.
// Parsed values are buffered in a first-word fall-through FIFO with a valid/ready output.
module sd_num_parser #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_en,
  input  logic [7:0]         in_byte,
  input  logic               flush,
  input  logic               clr_flags,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [DATA_W-1:0]  o_data,
  output logic [FIFO_AW:0]   fifo_level,
  output logic [15:0]        num_count,
  output logic               ovf_flag,
  output logic               drop_flag,
  output logic               bad_flag
);

  localparam int unsigned Depth = 2 ** FIFO_AW;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StNum  = 2'd1;
  localparam logic [1:0] StErr  = 2'd2;

  localparam logic [FIFO_AW:0]   LvlFull = (FIFO_AW + 1)'(Depth);
  localparam logic [FIFO_AW:0]   LvlOne  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PtrOne  = FIFO_AW'(1);
  localparam logic [DATA_W+3:0]  AccMax  = {4'd0, {DATA_W{1'b1}}};

  logic [1:0]          state_q, state_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                push_req;
  logic [DATA_W-1:0]   push_val;
  logic                is_digit, is_delim;
  logic [3:0]          digit;
  logic [DATA_W+3:0]   prod;
  logic                ovf_set, bad_set, drop_set;

  logic [DATA_W-1:0]   mem_q [Depth];
  logic [FIFO_AW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [FIFO_AW:0]    level_q, level_d;
  logic [DATA_W-1:0]   last_q, last_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                ovf_q, ovf_d, drop_q, drop_d, bad_q, bad_d;
  logic                full, pop, push_ok;

  always_comb begin
    is_digit = (in_byte >= 8'h30) && (in_byte <= 8'h39);
    is_delim = in_byte inside {8'h20, 8'h09, 8'h0D, 8'h0A, 8'h2C};
    digit    = in_byte[3:0];
    prod     = ({4'd0, acc_q} << 3) + ({4'd0, acc_q} << 1) + {{DATA_W{1'b0}}, digit};

    state_d  = state_q;
    acc_d    = acc_q;
    push_req = 1'b0;
    push_val = acc_q;
    ovf_set  = 1'b0;
    bad_set  = 1'b0;

    if (in_en) begin
      case (state_q)
        StIdle: begin
          if (is_digit) begin
            state_d = StNum;
            acc_d   = {{(DATA_W - 4){1'b0}}, digit};
          end else if (!is_delim) begin
            state_d = StErr;
            bad_set = 1'b1;
          end
        end
        StNum: begin
          if (is_digit) begin
            // Saturate and stay in StNum so the clipped value is still emitted.
            if (prod > AccMax) begin
              acc_d   = {DATA_W{1'b1}};
              ovf_set = 1'b1;
            end else begin
              acc_d = prod[DATA_W-1:0];
            end
          end else if (is_delim) begin
            push_req = 1'b1;
            push_val = acc_q;
            state_d  = StIdle;
            acc_d    = '0;
          end else begin
            state_d = StErr;
            bad_set = 1'b1;
            acc_d   = '0;
          end
        end
        StErr: begin
          if (is_delim) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end

    // Flush acts on the state after this cycle's byte has been consumed.
    if (flush) begin
      if (state_d == StNum) begin
        push_req = 1'b1;
        push_val = acc_d;
        state_d  = StIdle;
        acc_d    = '0;
      end else if (state_d == StErr) begin
        state_d = StIdle;
      end
    end
  end

  always_comb begin
    o_valid  = (level_q != '0);
    full     = (level_q == LvlFull);
    pop      = o_valid && o_ready;
    push_ok  = push_req && (!full || pop);
    drop_set = push_req && full && !pop;

    wptr_d  = push_ok ? wptr_q + PtrOne : wptr_q;
    rptr_d  = pop ? rptr_q + PtrOne : rptr_q;
    last_d  = pop ? mem_q[rptr_q] : last_q;
    cnt_d   = push_ok ? cnt_q + 16'd1 : cnt_q;
    level_d = level_q;
    if (push_ok && !pop) begin
      level_d = level_q + LvlOne;
    end else if (!push_ok && pop) begin
      level_d = level_q - LvlOne;
    end

    ovf_d  = (ovf_q && !clr_flags) || ovf_set;
    drop_d = (drop_q && !clr_flags) || drop_set;
    bad_d  = (bad_q && !clr_flags) || bad_set;

    o_data     = o_valid ? mem_q[rptr_q] : last_q;
    fifo_level = level_q;
    num_count  = cnt_q;
    ovf_flag   = ovf_q;
    drop_flag  = drop_q;
    bad_flag   = bad_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      acc_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
      bad_q   <= bad_d;
    end
  end

  // Storage needs no reset: entries are only read while the level covers them.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= push_val;
  end

endmodule

// File: tb/tb_sd_num_parser.sv
// Randomized and directed bench for sd_num_parser with a text-level reference model
// feeding an expected-value queue that a separate monitor drains.
module tb_sd_num_parser;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_en = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        flush = 1'b0;
  logic        clr_flags = 1'b0;
  logic        o_ready = 1'b0;
  logic        o_valid;
  logic [15:0] o_data;
  logic [4:0]  fifo_level;
  logic [15:0] num_count;
  logic        ovf_flag, drop_flag, bad_flag;

  sd_num_parser #(.DATA_W(16), .FIFO_AW(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_en      (in_en),
    .in_byte    (in_byte),
    .flush      (flush),
    .clr_flags  (clr_flags),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .o_data     (o_data),
    .fifo_level (fifo_level),
    .num_count  (num_count),
    .ovf_flag   (ovf_flag),
    .drop_flag  (drop_flag),
    .bad_flag   (bad_flag)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int unsigned exp_q[$];
  int unsigned last_data = 0;

  // Reference model: text-level view of the stream, values kept unbounded then clipped.
  bit          m_in_num = 0;
  bit          m_in_err = 0;
  longint      m_val = 0;
  int          m_level = 0;
  int unsigned m_count = 0;
  bit          m_ovf = 0, m_drop = 0, m_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : model
    bit     digit, delim, term, pop, s_ovf, s_bad, s_drop;
    longint tval;
    if (!rstn) begin
      m_in_num = 0; m_in_err = 0; m_val = 0; m_level = 0; m_count = 0;
      m_ovf = 0; m_drop = 0; m_bad = 0;
      exp_q.delete();
    end else begin
      chk("fifo_level", 32'(fifo_level), 32'(m_level));
      chk("num_count", 32'(num_count), m_count);
      chk("ovf_flag", 32'(ovf_flag), 32'(m_ovf));
      chk("drop_flag", 32'(drop_flag), 32'(m_drop));
      chk("bad_flag", 32'(bad_flag), 32'(m_bad));
      chk("o_valid", 32'(o_valid), 32'(m_level > 0));

      pop = o_ready && (m_level > 0);
      term = 0; tval = 0; s_ovf = 0; s_bad = 0; s_drop = 0;
      if (in_en) begin
        digit = (in_byte >= "0") && (in_byte <= "9");
        delim = (in_byte == 8'h20) || (in_byte == 8'h09) || (in_byte == 8'h0D) ||
                (in_byte == 8'h0A) || (in_byte == 8'h2C);
        if (m_in_err) begin
          if (delim) m_in_err = 0;
        end else if (m_in_num) begin
          if (digit) begin
            m_val = m_val * 10 + longint'(in_byte - "0");
            if (m_val > 65535) begin
              s_ovf = 1;
              m_val = 65536;
            end
          end else if (delim) begin
            term = 1; tval = m_val; m_in_num = 0;
          end else begin
            s_bad = 1; m_in_num = 0; m_in_err = 1;
          end
        end else begin
          if (digit) begin
            m_in_num = 1; m_val = longint'(in_byte - "0");
          end else if (!delim) begin
            s_bad = 1; m_in_err = 1;
          end
        end
      end
      if (flush) begin
        if (m_in_num) begin
          term = 1; tval = m_val; m_in_num = 0;
        end
        m_in_err = 0;
      end
      if (term) begin
        if (m_level == 16 && !pop) begin
          s_drop = 1;
        end else begin
          exp_q.push_back((tval > 65535) ? 32'd65535 : 32'(tval));
          m_count = (m_count + 1) % 65536;
          m_level++;
        end
      end
      if (pop) m_level--;
      m_ovf  = (m_ovf && !clr_flags) || s_ovf;
      m_bad  = (m_bad && !clr_flags) || s_bad;
      m_drop = (m_drop && !clr_flags) || s_drop;
    end
  end

  always @(negedge clk) begin : monitor
    if (!rstn) begin
      last_data = 0;
    end else if (o_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_o_valid", 32'(o_data), 32'hFFFF_FFFF);
      end else begin
        chk("o_data", 32'(o_data), exp_q[0]);
        if (o_ready) last_data = exp_q.pop_front();
      end
    end else begin
      chk("o_data_hold", 32'(o_data), last_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b, input bit fl, input int gap);
    in_en = 1; in_byte = b; flush = fl;
    tick();
    in_en = 0; flush = 0;
    repeat (gap) tick();
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send(s[i], 1'b0, gap);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_o_valid"}, 32'(o_valid), 0);
    chk({tag, "_o_data"}, 32'(o_data), 0);
    chk({tag, "_level"}, 32'(fifo_level), 0);
    chk({tag, "_count"}, 32'(num_count), 0);
    chk({tag, "_flags"}, {29'd0, ovf_flag, drop_flag, bad_flag}, 0);
  endtask

  task automatic do_reset();
    rstn = 0;
    #1;
    check_zero("reset");
    repeat (2) tick();
    rstn = 1;
    tick();
  endtask

  task automatic drain();
    int n = 0;
    o_ready = 1;
    while ((exp_q.size() != 0 || m_level != 0) && n < 200) begin
      tick();
      n++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    tick();
  endtask

  initial begin
    int r;
    logic [7:0] delims [5];
    delims[0] = 8'h20; delims[1] = 8'h09; delims[2] = 8'h0D; delims[3] = 8'h0A; delims[4] = 8'h2C;

    #3;
    do_reset();

    o_ready = 1;
    send_str("12,345\n", 2);
    drain();
    chk("t1_count", 32'(num_count), 2);

    do_reset();
    send_str("70000 ", 2);
    drain();
    chk("t2_ovf", 32'(ovf_flag), 1);
    chk("t2_last", last_data, 65535);

    do_reset();
    send_str("1a2 3 x\n", 1);
    drain();
    chk("t3_bad", 32'(bad_flag), 1);
    chk("t3_count", 32'(num_count), 1);

    do_reset();
    o_ready = 0;
    for (int v = 0; v <= 16; v++) send_str($sformatf("%0d ", v), 0);
    tick();
    chk("t4_level", 32'(fifo_level), 16);
    chk("t4_drop", 32'(drop_flag), 1);
    chk("t4_count", 32'(num_count), 16);
    drain();
    chk("t4_last", last_data, 15);
    chk("t4_valid_low", 32'(o_valid), 0);

    do_reset();
    send_str("42", 1);
    send("7", 1'b1, 2);
    flush = 1; tick(); flush = 0; tick();
    drain();
    chk("t5_count", 32'(num_count), 1);
    chk("t5_value", last_data, 427);

    do_reset();
    o_ready = 0;
    for (int v = 0; v < 16; v++) send_str($sformatf("%0d ", v), 0);
    send("9", 1'b0, 1);
    in_en = 1; in_byte = " "; o_ready = 1;
    tick();
    in_en = 0; o_ready = 0;
    tick();
    chk("t6_level", 32'(fifo_level), 16);
    chk("t6_drop", 32'(drop_flag), 0);
    chk("t6_count", 32'(num_count), 17);
    send_str("98", 1);
    rstn = 0;
    #1;
    check_zero("midreset");
    tick();
    rstn = 1;
    tick();
    o_ready = 1;
    send_str("5 ", 1);
    drain();
    chk("t6_after_reset", last_data, 5);

    do_reset();
    for (int c = 0; c < 3000; c++) begin
      in_en = ($urandom_range(0, 1) == 1);
      r = $urandom_range(0, 19);
      if (r < 12)      in_byte = 8'h30 + 8'($urandom_range(0, 9));
      else if (r < 17) in_byte = delims[$urandom_range(0, 4)];
      else             in_byte = 8'($urandom_range(0, 255));
      flush = ($urandom_range(0, 15) == 0);
      clr_flags = ($urandom_range(0, 31) == 0);
      o_ready = (c % 400 < 150) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
      tick();
    end
    in_en = 0; flush = 0; clr_flags = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_num_parser.md
Name: sd_num_parser

Overview:
- Downstream consumer of the SD file reader's byte stream (one-cycle strobe plus byte, no backpressure).
- Parses ASCII decimal numbers separated by delimiters into unsigned DATA_W-bit values.
- Buffers the values in an internal FIFO and presents them on a valid/ready interface to the display/test stage or to a memory writer.
- Reports overflow, dropped values and a count of accepted values.

Parameters:
- DATA_W, 16, width of each parsed value.
- FIFO_AW, 4, FIFO address width; depth is 2**FIFO_AW (16).

Ports:
- clk  input  1  system clock (50 MHz domain of the file reader).
- rstn  input  1  reset, asynchronous, active-low.
- in_en  input  1  byte strobe; in_byte is valid when this is high.
- in_byte  input  8  file content byte.
- flush  input  1  one-cycle pulse at end of file; terminates any pending number.
- clr_flags  input  1  synchronous clear of ovf_flag, drop_flag and bad_flag.
- o_valid  output  1  o_data holds a value.
- o_ready  input  1  consumer accepts the value; a pop occurs when o_valid and o_ready are both high.
- o_data  output  DATA_W  head-of-FIFO value.
- fifo_level  output  FIFO_AW+1  current occupancy, 0..2**FIFO_AW.
- num_count  output  16  number of values pushed; wraps at 65535 to 0.
- ovf_flag  output  1  sticky: some value exceeded 2**DATA_W-1.
- drop_flag  output  1  sticky: a value was lost because the FIFO was full.
- bad_flag  output  1  sticky: an invalid character was seen.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rstn.
- Reset values: all outputs 0 (o_valid=0, o_data=0, fifo_level=0, num_count=0, all flags 0); FSM in IDLE; accumulator 0; FIFO empty.
- Character classes:
  - digit: 0x30..0x39.
  - delimiter: 0x20, 0x09, 0x0D, 0x0A, 0x2C.
  - anything else: invalid.
- FSM, evaluated only on cycles with in_en=1:
  - IDLE: digit -> NUM, acc=digit. Delimiter -> stay in IDLE. Invalid -> ERR, bad_flag=1.
  - NUM: digit -> acc=acc*10+digit. Delimiter -> push acc, go to IDLE. Invalid -> ERR, bad_flag=1, discard acc, no push.
  - ERR: delimiter -> IDLE. Digit or invalid -> stay in ERR.
- Arithmetic:
  - Compute acc*10+digit at DATA_W+4 bits.
  - If the result exceeds 2**DATA_W-1, acc saturates to all-ones, ovf_flag=1, and the FSM stays in NUM.
  - Later digits keep acc saturated.
- Flush:
  - On a flush cycle with in_en=0: if in NUM, push acc and go to IDLE. If in ERR, go to IDLE. If in IDLE, no action.
  - If flush and in_en are high in the same cycle, the byte is processed first and flush is then applied to the resulting state.
  - At most one push occurs per cycle.
- FIFO:
  - Synchronous write: the push is registered on the same edge that samples the terminating byte or flush.
  - Output is first-word fall-through with registered flags: o_valid rises the cycle after the push edge when the FIFO was empty.
  - o_data is stable while o_valid=1 and o_ready=0.
- Full FIFO:
  - A push without a simultaneous pop is dropped: drop_flag=1, num_count unchanged.
  - A push with a simultaneous pop while full succeeds; the level stays at 2**FIFO_AW.
- Empty FIFO: o_valid=0; o_ready is ignored; o_data holds its last value.
- Pointers wrap modulo 2**FIFO_AW.
- fifo_level = pushes minus pops and is updated every edge.
- num_count increments on every successful push.
- clr_flags clears the three flags. If a flag-setting event occurs in the same cycle, the set wins.
- Reset mid-number: the partial acc is discarded, nothing is emitted, and FIFO contents are lost.

Test Plan:
- Stream "12,345\n" with one byte every 3 cycles, o_ready=1 -> o_data 12 then 345; num_count=2; all flags 0.
- Stream "70000 " -> 65535 pushed; ovf_flag=1; num_count=1.
- Stream "1a2 3 x\n" -> only 3 pushed; bad_flag=1; num_count=1.
- o_ready=0, stream "0 1 2 ... 16 " (17 values) -> fifo_level=16; drop_flag=1; num_count=16. Then raise o_ready -> pops 0..15 in order; o_valid falls after the 16th pop.
- Stream "42" then flush coincident with in_en on byte '7' -> single value 427 pushed, num_count=1. A flush in IDLE pushes nothing.
- FIFO full, o_ready=1 and a delimiter push in the same cycle -> level stays 16, no drop. Assert rstn=0 mid-number "98" -> all outputs 0; after release, "5 " yields 5.
